// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - shared register map, access-size codes and store-lane helpers
package mmio_pkg;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'hFFFF_FF00;

  localparam logic [3:0] OFF_CTRL   = 4'h0;
  localparam logic [3:0] OFF_DUTY   = 4'h4;
  localparam logic [3:0] OFF_PRESC  = 4'h8;
  localparam logic [3:0] OFF_MILLIS = 4'hC;

  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_HALF = 3'b001;
  localparam logic [2:0] F3_WORD = 3'b010;

  typedef enum logic [1:0] {
    REG_CTRL   = OFF_CTRL[3:2],
    REG_DUTY   = OFF_DUTY[3:2],
    REG_PRESC  = OFF_PRESC[3:2],
    REG_MILLIS = OFF_MILLIS[3:2]
  } reg_sel_e;

  // Misaligned or unsupported sizes yield an empty mask, so they write nothing.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (f3)
      F3_BYTE: m = 4'b0001 << a;
      F3_HALF: if (!a[0]) m = a[1] ? 4'b1100 : 4'b0011;
      F3_WORD: if (a == 2'b00) m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      F3_BYTE: return {4{d[7:0]}};
      F3_HALF: return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM colour channel with period-boundary shadow duty
module pwm_channel (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] duty,
  input  logic [7:0] pwm_cnt,
  input  logic       boundary,
  output logic       lit
);

  logic [7:0] shadow;

  // Shadow only moves at the period boundary so a duty write never glitches a period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow <= 8'd0;
      lit    <= 1'b0;
    end else begin
      if (boundary) shadow <= duty;
      lit <= (shadow > pwm_cnt);
    end
  end

endmodule

// File: rtl/mmio_led_pwm.sv
// rtl/mmio_led_pwm.sv - memory-mapped LED/RGB PWM peripheral with millisecond timer
module mmio_led_pwm
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
  parameter int unsigned CLK_FREQ_HZ    = 12_000_000,
  parameter logic [15:0] PRESC_RESET    = 16'd46,
  parameter bit          RGB_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmem_wren,
  input  logic [31:0] dmem_address,
  input  logic [31:0] dmem_data_in,
  input  logic [2:0]  funct3,
  output logic [31:0] mmio_data_out,
  output logic        mmio_hit,
  output logic        led,
  output logic        red,
  output logic        green,
  output logic        blue
);

  localparam logic [31:0] MS_LAST = 32'(CLK_FREQ_HZ / 1000 - 1);

  logic        hit;
  logic        wr;
  logic [3:0]  lanes;
  logic [31:0] wdata;
  reg_sel_e    sel;
  logic [23:0] duty;
  logic [15:0] presc;
  logic [31:0] millis;
  logic [31:0] ms_div;
  logic [15:0] presc_cnt;
  logic [7:0]  pwm_cnt;
  logic        presc_clr;
  logic        pwm_tick;
  logic        boundary;
  logic        r_lit, g_lit, b_lit;
  logic [31:0] rd_word;
  logic        unused_wdata_hi;

  assign hit   = (dmem_address[31:4] == BASE_ADDR[31:4]);
  assign lanes = lane_mask(funct3, dmem_address[1:0]);
  assign wdata = lane_data(funct3, dmem_data_in);
  assign sel   = reg_sel_e'(dmem_address[3:2]);
  assign wr    = dmem_wren && hit;
  assign unused_wdata_hi = ^wdata[31:24];

  assign presc_clr = wr && (sel == REG_PRESC) && (|lanes[1:0]);
  assign pwm_tick  = !presc_clr && (presc_cnt == presc);
  assign boundary  = pwm_tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led   <= 1'b0;
      duty  <= 24'd0;
      presc <= PRESC_RESET;
    end else if (wr) begin
      case (sel)
        REG_CTRL: if (lanes[0]) led <= wdata[0];
        REG_DUTY: begin
          for (int i = 0; i < 3; i++)
            if (lanes[i]) duty[8*i +: 8] <= wdata[8*i +: 8];
        end
        REG_PRESC: begin
          if (lanes[0]) presc[7:0]  <= wdata[7:0];
          if (lanes[1]) presc[15:8] <= wdata[15:8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ms_div <= 32'd0;
      millis <= 32'd0;
    end else if (ms_div == MS_LAST) begin
      ms_div <= 32'd0;
      millis <= millis + 32'd1;
    end else begin
      ms_div <= ms_div + 32'd1;
    end
  end

  // A PRESC write restarts the prescale count so the new rate starts cleanly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_cnt <= 16'd0;
      pwm_cnt   <= 8'd0;
    end else if (presc_clr) begin
      presc_cnt <= 16'd0;
    end else if (pwm_tick) begin
      presc_cnt <= 16'd0;
      pwm_cnt   <= pwm_cnt + 8'd1;
    end else begin
      presc_cnt <= presc_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_word = 32'd0;
    case (sel)
      REG_CTRL:   rd_word = {31'd0, led};
      REG_DUTY:   rd_word = {8'd0, duty};
      REG_PRESC:  rd_word = {16'd0, presc};
      REG_MILLIS: rd_word = millis;
      default:    rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_data_out <= 32'd0;
      mmio_hit      <= 1'b0;
    end else begin
      mmio_data_out <= hit ? rd_word : 32'd0;
      mmio_hit      <= hit;
    end
  end

  pwm_channel u_red (
    .clk(clk), .reset(reset), .duty(duty[7:0]), .pwm_cnt(pwm_cnt),
    .boundary(boundary), .lit(r_lit)
  );

  pwm_channel u_green (
    .clk(clk), .reset(reset), .duty(duty[15:8]), .pwm_cnt(pwm_cnt),
    .boundary(boundary), .lit(g_lit)
  );

  pwm_channel u_blue (
    .clk(clk), .reset(reset), .duty(duty[23:16]), .pwm_cnt(pwm_cnt),
    .boundary(boundary), .lit(b_lit)
  );

  assign red   = r_lit ^ RGB_ACTIVE_LOW;
  assign green = g_lit ^ RGB_ACTIVE_LOW;
  assign blue  = b_lit ^ RGB_ACTIVE_LOW;

endmodule

// File: tb/tb_mmio_led_pwm.sv
// tb/tb_mmio_led_pwm.sv - self-checking bench for mmio_led_pwm against a byte-window model
module tb_mmio_led_pwm;
  import mmio_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int unsigned FREQ = 4000;
  localparam int unsigned DIV  = FREQ / 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dmem_wren = 1'b0;
  logic [31:0] dmem_address = 32'd0;
  logic [31:0] dmem_data_in = 32'd0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] mmio_data_out;
  logic        mmio_hit, led, red, green, blue;

  int          checks = 0;
  int          errors = 0;
  int unsigned edge_cnt;
  int unsigned store_edge;
  logic [7:0]  win [16];
  logic [7:0]  shadow_exp [3];
  logic [31:0] ms_base;
  int unsigned ms_base_edge;

  mmio_led_pwm #(
    .BASE_ADDR(BASE), .CLK_FREQ_HZ(FREQ), .PRESC_RESET(16'd46), .RGB_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .dmem_wren(dmem_wren), .dmem_address(dmem_address),
    .dmem_data_in(dmem_data_in), .funct3(funct3), .mmio_data_out(mmio_data_out),
    .mmio_hit(mmio_hit), .led(led), .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) edge_cnt <= 0;
    else edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
    end
  endtask

  function automatic logic [7:0] wmask(input int idx);
    case (idx)
      0:             return 8'h01;
      4, 5, 6, 8, 9: return 8'hFF;
      default:       return 8'h00;
    endcase
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    return (a & 32'hFFFF_FFF0) == BASE;
  endfunction

  task automatic model_reset();
    foreach (win[i]) win[i] = 8'h00;
    win[8] = 8'd46;
    ms_base = 32'd0;
    ms_base_edge = 0;
  endtask

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    int size;
    int off;
    if (!in_window(a)) return;
    case (f)
      F3_BYTE: size = 1;
      F3_HALF: size = 2;
      F3_WORD: size = 4;
      default: return;
    endcase
    if ((int'(a[1:0]) % size) != 0) return;
    off = int'(a[3:0]);
    for (int b = 0; b < size; b++) win[off + b] = d[8*b +: 8] & wmask(off + b);
  endtask

  function automatic logic [31:0] millis_after(input int unsigned k);
    return ms_base + 32'(k / DIV) - 32'(ms_base_edge / DIV);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a, input int unsigned e);
    int off;
    if (!in_window(a)) return 32'd0;
    off = int'(a[3:2]) * 4;
    if (off == 12) return millis_after(e - 1);
    return {win[off + 3], win[off + 2], win[off + 1], win[off]};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    dmem_wren = 1'b0;
    dmem_address = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    dmem_address = a;
    dmem_data_in = d;
    funct3 = f;
    dmem_wren = 1'b1;
    store_edge = edge_cnt + 1;
    model_store(a, d, f);
    @(negedge clk);
    dmem_wren = 1'b0;
    dmem_address = 32'd0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, output logic [31:0] obs);
    dmem_address = a;
    dmem_wren = 1'b0;
    @(negedge clk);
    obs = mmio_data_out;
    check({tag, "_data"}, obs, model_word(a, edge_cnt));
    check({tag, "_hit"}, 32'(mmio_hit), 32'(in_window(a)));
    dmem_address = 32'd0;
  endtask

  task automatic wait_until(input int unsigned target, input string tag);
    int guard = 0;
    while (edge_cnt < target && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check(tag, edge_cnt, target);
  endtask

  // Counts lit cycles over one aligned PWM period, optionally issuing one store inside it.
  task automatic count_period(input string tag, input int unsigned start, input int mid_idx,
                              input logic [31:0] ma, input logic [31:0] md, input logic [2:0] mf);
    int         cnt [3];
    logic [7:0] want [3];
    logic [7:0] nxt [3];
    wait_until(start, {tag, "_sync"});
    want = shadow_exp;
    nxt = shadow_exp;
    cnt = '{0, 0, 0};
    for (int i = 0; i < 256; i++) begin
      if (red == 1'b0)   cnt[0]++;
      if (green == 1'b0) cnt[1]++;
      if (blue == 1'b0)  cnt[2]++;
      if (i == 254) nxt = '{win[4], win[5], win[6]};
      if (i == mid_idx) begin
        dmem_address = ma;
        dmem_data_in = md;
        funct3 = mf;
        dmem_wren = 1'b1;
        model_store(ma, md, mf);
      end else begin
        dmem_wren = 1'b0;
        dmem_address = 32'd0;
      end
      @(negedge clk);
    end
    dmem_wren = 1'b0;
    dmem_address = 32'd0;
    check({tag, "_red_lit"},   32'(cnt[0]), 32'(want[0]));
    check({tag, "_green_lit"}, 32'(cnt[1]), 32'(want[1]));
    check({tag, "_blue_lit"},  32'(cnt[2]), 32'(want[2]));
    shadow_exp = nxt;
  endtask

  initial begin
    logic [31:0] obs;
    logic [31:0] a, d;
    logic [2:0]  f;
    int unsigned pick;
    int unsigned w;

    apply_reset();
    repeat (10) @(negedge clk);
    check("rst_led", 32'(led), 32'd0);
    check("rst_red", 32'(red), 32'd1);
    check("rst_green", 32'(green), 32'd1);
    check("rst_blue", 32'(blue), 32'd1);
    check("rst_hit", 32'(mmio_hit), 32'd0);
    check("rst_data", mmio_data_out, 32'd0);
    read_check("presc_rst", BASE + 32'(OFF_PRESC), obs);
    check("presc_rst_val", obs, 32'h0000_002E);
    read_check("ctrl_rst", BASE + 32'(OFF_CTRL), obs);

    do_store(BASE + 32'h4, 32'h0033_2211, F3_WORD);
    do_store(BASE + 32'h5, 32'h0000_AAAA, F3_HALF);
    do_store(BASE + 32'hC, 32'hDEAD_BEEF, F3_WORD);
    do_store(BASE + 32'h10, 32'h5555_5555, F3_WORD);
    do_store(BASE + 32'h4, 32'h0000_0077, 3'b011);
    read_check("duty_bad", BASE + 32'h4, obs);
    check("duty_bad_val", obs, 32'h0033_2211);
    do_store(BASE + 32'h6, 32'h0000_BEEF, F3_HALF);
    read_check("duty_sh", BASE + 32'h4, obs);
    check("duty_sh_val", obs, 32'h00EF_2211);
    read_check("millis_rd", BASE + 32'(OFF_MILLIS), obs);
    read_check("miss_rd", BASE + 32'h10, obs);

    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 9);
      if (pick < 8)       a = BASE + 32'($urandom_range(0, 15));
      else if (pick == 8) a = BASE + 32'h10 + 32'($urandom_range(0, 15));
      else                a = $urandom;
      f = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      d = $urandom;
      do_store(a, d, f);
      check("led_track", 32'(led), 32'(win[0][0]));
      if (n % 6 == 5)
        for (int r = 0; r < 4; r++) read_check("rand_rd", BASE + 32'(4 * r), obs);
    end

    apply_reset();
    dmem_address = BASE + 32'(OFF_MILLIS);
    wait_until(41, "ms_wait");
    check("millis_40", mmio_data_out, 32'd10);
    do_store(BASE + 32'(OFF_MILLIS), 32'h1234_5678, F3_WORD);
    read_check("millis_ro", BASE + 32'(OFF_MILLIS), obs);
    force dut.millis = 32'hFFFF_FFFF;
    #1;
    release dut.millis;
    ms_base = 32'hFFFF_FFFF;
    ms_base_edge = edge_cnt;
    repeat (DIV) @(negedge clk);
    read_check("millis_wrap", BASE + 32'(OFF_MILLIS), obs);
    check("millis_wrap_val", obs, 32'd0);

    apply_reset();
    do_store(BASE + 32'h4, 32'h00FF_8040, F3_WORD);
    do_store(BASE + 32'h8, 32'h0000_0000, F3_WORD);
    w = store_edge;
    shadow_exp = '{win[4], win[5], win[6]};
    count_period("p1", w + 257,  128, BASE + 32'h5, 32'h40, F3_BYTE);
    count_period("p2", w + 513,  128, BASE + 32'h5, 32'h80, F3_BYTE);
    count_period("p3", w + 769,  254, BASE + 32'h4, 32'h10, F3_BYTE);
    count_period("p4", w + 1025, -1, 32'd0, 32'd0, F3_BYTE);
    count_period("p5", w + 1281, -1, 32'd0, 32'd0, F3_BYTE);
    read_check("duty_pwm", BASE + 32'h4, obs);
    check("duty_pwm_val", obs, 32'h00FF_8010);

    dmem_address = BASE + 32'(OFF_CTRL);
    dmem_data_in = 32'd1;
    funct3 = F3_WORD;
    dmem_wren = 1'b1;
    model_store(BASE, 32'd1, F3_WORD);
    check("led_before", 32'(led), 32'd0);
    @(negedge clk);
    dmem_wren = 1'b0;
    check("led_after", 32'(led), 32'd1);
    dmem_address = BASE + 32'h4;
    repeat (2) @(negedge clk);
    check("pre_rst_hit", 32'(mmio_hit), 32'd1);
    check("pre_rst_data", mmio_data_out, model_word(BASE + 32'h4, edge_cnt));
    #3;
    reset = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_red", 32'(red), 32'd1);
    check("arst_green", 32'(green), 32'd1);
    check("arst_blue", 32'(blue), 32'd1);
    check("arst_hit", 32'(mmio_hit), 32'd0);
    check("arst_data", mmio_data_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    dmem_address = 32'd0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_led_pwm.md
Name: mmio_led_pwm

Overview:
Memory-mapped LED/RGB peripheral that consumes the core's data-memory store/load bus, downstream of the multicycle core's address/data registers. Decodes a small register window, holds an LED bit, 8-bit R/G/B duty cycles, a PWM prescaler and a free-running millisecond timer. Drives LED and RGB_R/G/B pins with glitch-free PWM. Returns registered read data plus a hit flag so the memory read mux can select it.

Parameters:
BASE_ADDR, 32'hFFFF_FF00, word-aligned base of the 16-byte register window
CLK_FREQ_HZ, 12_000_000, clk frequency; sets the 1 ms timer divisor
PRESC_RESET, 16'd46, reset value of the PWM prescaler register
RGB_ACTIVE_LOW, 1, 1 = RGB pins low when lit

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
dmem_wren  input  1  store strobe from core, one cycle per store
dmem_address  input  32  byte address, held by core for the access
dmem_data_in  input  32  store data, right-aligned (rs2 value)
funct3  input  3  access size: 000 byte, 001 half, 010 word
mmio_data_out  output  32  registered read data, full aligned word
mmio_hit  output  1  registered: previous-cycle address fell in window
led  output  1  LED pin, active-high
red, green, blue  output  1 each  RGB pins, polarity per RGB_ACTIVE_LOW

Behaviour:
- Register map (offset from BASE_ADDR): 0x0 CTRL (bit0 = led, rest read 0); 0x4 DUTY (byte0 R, byte1 G, byte2 B, byte3 reads 0); 0x8 PRESC (bits15:0, rest read 0); 0xC MILLIS (32-bit, read-only).
- Hit: dmem_address[31:4] == BASE_ADDR[31:4]. Non-hit stores ignored.
- Stores: byte lanes from address[1:0]. sb writes lane addr[1:0] with data[7:0]; sh requires addr[0]=0, writes lanes addr[1]*2+{0,1} with data[15:0]; sw requires addr[1:0]=0. Misaligned or funct3 not in {000,001,010}: ignored, no side effect. Writes to MILLIS and to undefined bits ignored.
- Reads: every cycle mmio_data_out <= register word at address[3:2] (0 if not hit); mmio_hit <= hit. Latency 1 cycle, matching block-RAM read timing.
- Timer: ms_div counts 0..CLK_FREQ_HZ/1000-1; on terminal count MILLIS increments, wraps 0xFFFF_FFFF->0.
- PWM: presc_cnt counts 0..PRESC; at PRESC, presc_cnt->0 and pwm_cnt (8-bit) increments, wrapping 255->0. Period = 256*(PRESC+1) clk cycles. PRESC=0 -> pwm_cnt advances every cycle.
- Writing PRESC clears presc_cnt that cycle.
- Shadow duties: shadow_{r,g,b} load from DUTY when pwm_cnt wraps 255->0 (period boundary). Lit = shadow > pwm_cnt; duty 0 never lit, 255 lit 255/256 of period.
- Write to DUTY on the same edge as a boundary load: shadow takes pre-write value; new value applies from next period.
- Pins registered (no combinational path to outputs); 1-cycle lag after the compare.
- led pin = CTRL bit0, registered, updates the cycle after the store.
- Reset (asserted anytime, incl. mid-period): CTRL=0, DUTY=0, shadows=0, PRESC=PRESC_RESET, all counters 0, MILLIS=0, mmio_data_out=0, mmio_hit=0, led=0, RGB pins at unlit level (1 if RGB_ACTIVE_LOW).

Decomposition:
- Shared package mmio_pkg: BASE_ADDR default, register offsets (OFF_CTRL/OFF_DUTY/OFF_PRESC/OFF_MILLIS), funct3 size codes (F3_BYTE/F3_HALF/F3_WORD) reused by memory.
- One sub-module pwm_channel: 8-bit duty in, shared pwm_cnt and boundary strobe in, holds shadow register, outputs registered lit bit. Instantiated 3x.

Test Plan:
- Reset then idle 10 cycles -> led=0, red/green/blue=1, mmio_hit=0, mmio_data_out=0; read PRESC -> 0x0000002E.
- sw 0x00FF8040 to BASE+0x4, PRESC=0 -> after next period boundary, per 256-cycle period R lit 64 cycles, G lit 128, B lit 255.
- sb 0x80 to BASE+0x5 mid-period with G=0x40 -> G keeps 64 lit cycles that period, 128 from the next; R/B lanes unchanged on readback.
- sh to BASE+0x5 (misaligned), sw to BASE+0xC, sw to BASE+0x10 -> no register changes; readback of DUTY/MILLIS unaffected.
- CLK_FREQ_HZ=4000 (div 4): 40 cycles after reset MILLIS reads 10; sw to MILLIS ignored; preload-free wrap checked by forcing 0xFFFFFFFF -> next ms reads 0.
- sw 1 to BASE+0x0 -> led=1 exactly one cycle later; assert reset mid-PWM period -> all outputs return to reset values immediately, asynchronously.
